fc_layer_controller: RTL and testbench

- Sequences one fully-connected layer. For each output neuron it reads IN_SZ inputs and weights from synchronous memories, then multiply-accumulates them in fixed point.
- It adds a per-neuron bias, saturates the result, and optionally applies ReLU.
- Each result is written into the neuron layer register bank through its load_en / load_address / load_value port.
- It sits between the top-level FC sequencer (start/done) and the layer storage.

---
 rtl/fc_layer_controller_if.sv | 26 ++
 rtl/fc_layer_controller.sv | 160 ++++++++++++++++
 tb/tb_fc_layer_controller.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fc_layer_controller_if.sv
// rtl/fc_layer_controller_if.sv - memory and layer-bank bus between the FC layer controller and its storage
interface fc_layer_controller_if #(
    parameter int SIZE     = 16,
    parameter int W_ADDR_W = 16
);
    logic [SIZE-1:0]     in_addr;
    logic [SIZE-1:0]     in_data;
    logic [W_ADDR_W-1:0] w_addr;
    logic [SIZE-1:0]     w_data;
    logic [SIZE-1:0]     b_addr;
    logic [SIZE-1:0]     b_data;
    logic                layer_reset;
    logic                load_en;
    logic [SIZE-1:0]     load_address;
    logic [SIZE-1:0]     load_value;

    modport master (
        output in_addr, w_addr, b_addr, layer_reset, load_en, load_address, load_value,
        input  in_data, w_data, b_data
    );

    modport slave (
        input  in_addr, w_addr, b_addr, layer_reset, load_en, load_address, load_value,
        output in_data, w_data, b_data
    );
endinterface

// File: rtl/fc_layer_controller.sv
// rtl/fc_layer_controller.sv - sequences one fully-connected layer: MAC, bias, saturate, optional ReLU, write-back
module fc_layer_controller #(
    parameter int SIZE     = 16,
    parameter int FRAC     = 8,
    parameter int IN_SZ    = 400,
    parameter int LAYER_SZ = 120,
    parameter int W_ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  relu_en,
    output logic                  busy,
    output logic                  done,
    fc_layer_controller_if.master mem
);
    localparam int K_W   = (IN_SZ > 1) ? $clog2(IN_SZ) : 1;
    localparam int N_W   = (LAYER_SZ > 1) ? $clog2(LAYER_SZ) : 1;
    localparam int ACC_W = 2*SIZE + $clog2(IN_SZ);

    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W+2-SIZE){1'b0}}, {(SIZE-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W+2-SIZE){1'b1}}, {(SIZE-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_MAC, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    state_t                   state;
    state_t                   state_nx;
    logic [K_W-1:0]           k;
    logic [N_W-1:0]           n;
    logic signed [ACC_W-1:0]  acc;
    logic                     relu_q;
    logic                     k_last;
    logic                     n_last;
    logic signed [2*SIZE-1:0] prod;
    logic signed [ACC_W:0]    bias_ext;
    logic signed [ACC_W:0]    sum;
    logic [SIZE-1:0]          result;

    assign k_last = (k == K_W'(IN_SZ-1));
    assign n_last = (n == N_W'(LAYER_SZ-1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nx = S_CLEAR;
                S_CLEAR: state_nx = S_MAC;
                S_MAC:   if (k_last) state_nx = S_DRAIN;
                S_DRAIN: state_nx = S_WRITE;
                S_WRITE: state_nx = n_last ? S_DONE : S_MAC;
                S_DONE:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Memory data lags the address by one cycle, so the product seen in MAC is for k-1.
    assign prod = (2*SIZE)'($signed(mem.in_data)) * (2*SIZE)'($signed(mem.w_data));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k      <= '0;
            n      <= '0;
            acc    <= '0;
            relu_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) relu_q <= relu_en;
                end
                S_CLEAR: begin
                    k   <= '0;
                    n   <= '0;
                    acc <= '0;
                end
                S_MAC: begin
                    if (!k_last) k <= k + K_W'(1);
                    if (k != '0) acc <= acc + ACC_W'(prod);
                end
                S_DRAIN: begin
                    acc <= acc + ACC_W'(prod);
                end
                S_WRITE: begin
                    acc <= '0;
                    k   <= '0;
                    if (!n_last) n <= n + N_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bias_ext = {{(ACC_W+1-SIZE){mem.b_data[SIZE-1]}}, mem.b_data};
    assign sum      = (ACC_W+1)'(acc >>> FRAC) + bias_ext;

    always_comb begin
        result = sum[SIZE-1:0];
        if (sum > SAT_MAX) begin
            result = {1'b0, {(SIZE-1){1'b1}}};
        end else if (sum < SAT_MIN) begin
            result = {1'b1, {(SIZE-1){1'b0}}};
        end
        if (relu_q && result[SIZE-1]) begin
            result = '0;
        end
    end

    // Addresses are gated by state so they read zero whenever the controller is idle.
    always_comb begin
        busy             = 1'b0;
        done             = 1'b0;
        mem.layer_reset  = 1'b0;
        mem.load_en      = 1'b0;
        mem.load_address = '0;
        mem.load_value   = '0;
        mem.in_addr      = '0;
        mem.w_addr       = '0;
        mem.b_addr       = '0;
        case (state)
            S_CLEAR: begin
                busy            = 1'b1;
                mem.layer_reset = 1'b1;
            end
            S_MAC: begin
                busy        = 1'b1;
                mem.in_addr = SIZE'(k);
                mem.w_addr  = W_ADDR_W'(n) * W_ADDR_W'(IN_SZ) + W_ADDR_W'(k);
                mem.b_addr  = SIZE'(n);
            end
            S_DRAIN: begin
                busy       = 1'b1;
                mem.b_addr = SIZE'(n);
            end
            S_WRITE: begin
                busy             = 1'b1;
                mem.b_addr       = SIZE'(n);
                mem.load_en      = 1'b1;
                mem.load_address = SIZE'(n);
                mem.load_value   = result;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fc_layer_controller.sv
// tb/tb_fc_layer_controller.sv - directed self-checking bench for fc_layer_controller
module tb_fc_layer_controller;
    localparam int SIZE     = 16;
    localparam int FRAC     = 8;
    localparam int IN_SZ    = 4;
    localparam int LAYER_SZ = 3;
    localparam int W_ADDR_W = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic start   = 1'b0;
    logic abort   = 1'b0;
    logic relu_en = 1'b0;
    logic busy;
    logic done;

    fc_layer_controller_if #(.SIZE(SIZE), .W_ADDR_W(W_ADDR_W)) mem ();

    fc_layer_controller #(
        .SIZE(SIZE), .FRAC(FRAC), .IN_SZ(IN_SZ), .LAYER_SZ(LAYER_SZ), .W_ADDR_W(W_ADDR_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .abort   (abort),
        .relu_en (relu_en),
        .busy    (busy),
        .done    (done),
        .mem     (mem)
    );

    always #5 clk = ~clk;

    logic [15:0] in_mem [4];
    logic [15:0] w_mem  [16];
    logic [15:0] b_mem  [4];

    always @(posedge clk) begin
        mem.in_data <= in_mem[mem.in_addr[1:0]];
        mem.w_data  <= w_mem[mem.w_addr[3:0]];
        mem.b_data  <= b_mem[mem.b_addr[1:0]];
    end

    int busy_cnt = 0;
    int done_cnt = 0;
    int lr_cnt   = 0;
    int wr_cnt   = 0;
    int ovl_cnt  = 0;
    logic [15:0] wr_addr [256];
    logic [15:0] wr_val  [256];

    always @(negedge clk) begin
        if (busy) busy_cnt <= busy_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (mem.layer_reset) lr_cnt <= lr_cnt + 1;
        if (mem.load_en && mem.layer_reset) ovl_cnt <= ovl_cnt + 1;
        if (mem.load_en) begin
            wr_addr[wr_cnt % 256] <= mem.load_address;
            wr_val[wr_cnt % 256]  <= mem.load_value;
            wr_cnt <= wr_cnt + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_mem(input logic [15:0] iv, input logic [15:0] wv,
                           input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2);
        for (int i = 0; i < 4; i++) in_mem[i] = iv;
        for (int i = 0; i < 16; i++) w_mem[i] = wv;
        b_mem[0] = b0;
        b_mem[1] = b1;
        b_mem[2] = b2;
        b_mem[3] = 16'h0000;
    endtask

    task automatic run_pass(input logic relu, input int hold,
                            output int bw, output int bb, output int bd, output int bl);
        int t;
        bw = wr_cnt;
        bb = busy_cnt;
        bd = done_cnt;
        bl = lr_cnt;
        @(negedge clk);
        start   = 1'b1;
        relu_en = relu;
        repeat (hold) @(negedge clk);
        start   = 1'b0;
        relu_en = 1'b0;
        t = 0;
        #1;
        while (done_cnt == bd && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("pass_timeout", (t < 200), 1);
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic check_pass(input string tg, input int bw, input int bb, input int bd, input int bl,
                              input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        logic [15:0] ev [3];
        ev[0] = e0;
        ev[1] = e1;
        ev[2] = e2;
        check({tg, "_busy"}, busy_cnt - bb, 19);
        check({tg, "_done"}, done_cnt - bd, 1);
        check({tg, "_lrst"}, lr_cnt - bl, 1);
        check({tg, "_nwr"},  wr_cnt - bw, 3);
        for (int i = 0; i < 3; i++) begin
            check({tg, "_addr"}, wr_addr[(bw + i) % 256], i);
            check({tg, "_val"},  wr_val[(bw + i) % 256], ev[i]);
        end
    endtask

    initial begin
        int bw, bb, bd, bl, t;

        set_mem(16'h0100, 16'h0080, 16'h0000, 16'h0000, 16'h0000);
        repeat (2) @(negedge clk);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_lrst",  mem.layer_reset, 0);
        check("rst_load",  mem.load_en, 0);
        check("rst_lval",  mem.load_value, 0);
        check("rst_laddr", mem.load_address, 0);
        check("rst_iaddr", mem.in_addr, 0);
        check("rst_waddr", mem.w_addr, 0);
        check("rst_baddr", mem.b_addr, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_pass(1'b0, 1, bw, bb, bd, bl);
        check_pass("basic", bw, bb, bd, bl, 16'h0200, 16'h0200, 16'h0200);

        set_mem(16'h0100, 16'hFF80, 16'h0000, 16'h0100, 16'h0000);
        run_pass(1'b0, 1, bw, bb, bd, bl);
        check_pass("neg", bw, bb, bd, bl, 16'hFE00, 16'hFF00, 16'hFE00);
        run_pass(1'b1, 1, bw, bb, bd, bl);
        check_pass("relu", bw, bb, bd, bl, 16'h0000, 16'h0000, 16'h0000);

        set_mem(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000);
        run_pass(1'b0, 1, bw, bb, bd, bl);
        check_pass("satpos", bw, bb, bd, bl, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        set_mem(16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'h0000);
        run_pass(1'b0, 1, bw, bb, bd, bl);
        check_pass("satneg", bw, bb, bd, bl, 16'h8000, 16'h8000, 16'h8000);

        set_mem(16'h0000, 16'h0100, 16'h0010, 16'h0020, 16'h0030);
        for (int i = 0; i < 4; i++) in_mem[i] = 16'(i);
        run_pass(1'b0, 1, bw, bb, bd, bl);
        check_pass("latency", bw, bb, bd, bl, 16'h0016, 16'h0026, 16'h0036);

        set_mem(16'h0100, 16'h0080, 16'h0000, 16'h0000, 16'h0000);
        bw = wr_cnt;
        bd = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        #1;
        while (wr_cnt == bw && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("abort_wait", (t < 100), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        check("abort_nwr",  wr_cnt - bw, 1);
        check("abort_done", done_cnt - bd, 0);
        check("abort_busy", busy, 0);
        run_pass(1'b0, 1, bw, bb, bd, bl);
        check_pass("post_abort", bw, bb, bd, bl, 16'h0200, 16'h0200, 16'h0200);

        run_pass(1'b0, 10, bw, bb, bd, bl);
        check_pass("hold_start", bw, bb, bd, bl, 16'h0200, 16'h0200, 16'h0200);
        repeat (30) @(negedge clk);
        #1;
        check("hold_no_second", done_cnt - bd, 1);

        bd = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy",  busy, 1);
        check("mid_iaddr", mem.in_addr, 3);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy",  busy, 0);
        check("arst_lrst",  mem.layer_reset, 0);
        check("arst_load",  mem.load_en, 0);
        check("arst_iaddr", mem.in_addr, 0);
        check("arst_waddr", mem.w_addr, 0);
        check("arst_baddr", mem.b_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        check("arst_nodone", done_cnt - bd, 0);
        run_pass(1'b0, 1, bw, bb, bd, bl);
        check_pass("post_rst", bw, bb, bd, bl, 16'h0200, 16'h0200, 16'h0200);

        check("no_overlap", ovl_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
